// File: rtl/sync_reg_pkg.sv
// Shared definitions for the sync_cnt_regs register block: default widths,
// register byte offsets and the address decoder.
// Optional feature macro: SYNC_CNT_SNAPSHOT_EN (adds the SNAP register at 0x20).
package sync_reg_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 8;

  // Register byte offsets. The decoder zero-extends or truncates addresses to
  // 32 bits, so ADDR_W must be 32 or less.
  localparam logic [31:0] CNT_OFS    = 32'h00;
  localparam logic [31:0] RUN_OFS    = 32'h08;
  localparam logic [31:0] TRIG_OFS   = 32'h10;
  localparam logic [31:0] STATUS_OFS = 32'h18;
  localparam logic [31:0] SNAP_OFS   = 32'h20;

`ifdef SYNC_CNT_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    REG_CNT,
    REG_RUN,
    REG_TRIG,
    REG_STATUS,
    REG_SNAP,
    REG_NONE
  } reg_sel_e;

  // Map a byte address onto a register. An address that matches no register
  // (including SNAP when the snapshot feature is not built) gives REG_NONE.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    case (addr)
      CNT_OFS:    sel = REG_CNT;
      RUN_OFS:    sel = REG_RUN;
      TRIG_OFS:   sel = REG_TRIG;
      STATUS_OFS: sel = REG_STATUS;
      SNAP_OFS:   sel = SNAP_EN ? REG_SNAP : REG_NONE;
      default:    sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sync_cnt_regs_if.sv
// Synchronous register bus between the upstream AXI bridge (master) and the
// counter register block (slave). Separate write and read strobes, each
// answered one cycle later.
interface sync_cnt_regs_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
);

  logic              reg_wr_en;
  logic [ADDR_W-1:0] reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic              reg_wr_ack;

  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_rd_addr;
  logic [DATA_W-1:0] reg_rd_data;
  logic              reg_rd_valid;
  logic              reg_rd_err;

  modport master (
    output reg_wr_en, reg_wr_addr, reg_wr_data,
    input  reg_wr_ack,
    output reg_rd_en, reg_rd_addr,
    input  reg_rd_data, reg_rd_valid, reg_rd_err
  );

  modport slave (
    input  reg_wr_en, reg_wr_addr, reg_wr_data,
    output reg_wr_ack,
    input  reg_rd_en, reg_rd_addr,
    output reg_rd_data, reg_rd_valid, reg_rd_err
  );

endinterface

// File: rtl/sync_cnt_core.sv
// Counter datapath: holds CNT and applies load, add and free-running
// increment in one adder, reporting the carry out of the top bit.
module sync_cnt_core #(
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              ld_en_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              add_en_i,
  input  logic [DATA_W-1:0] add_data_i,
  output logic [DATA_W-1:0] cnt_o,
  output logic              carry_o
);

  localparam int SUM_W = DATA_W + 1;

  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  addend;
  logic [SUM_W-1:0]  inc;

  // Next count: a load overrides everything, otherwise add the TRIG value and
  // the run increment together so both land in the same cycle.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    carry_o = 1'b0;
    addend  = add_en_i ? {1'b0, add_data_i} : '0;
    inc     = {{DATA_W{1'b0}}, run_i};
    sum     = {1'b0, cnt_q} + addend + inc;
    if (ld_en_i) begin
      cnt_d = ld_data_i;
    end else if (run_i || add_en_i) begin
      cnt_d   = sum[DATA_W-1:0];
      carry_o = sum[DATA_W];
    end
  end

  // Counter register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sync_cnt_regs.sv
// Counter register block on a synchronous register bus: CNT, RUN, TRIG and a
// sticky overflow STATUS bit mirrored on cnt_ovf_irq. Reads return pre-edge
// register values one cycle after the strobe.
// Optional feature macro: SYNC_CNT_SNAPSHOT_EN adds SNAP at 0x20, which
// captures CNT whenever CNT is read.
module sync_cnt_regs
  import sync_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                ACLK,
  input  logic                ARESET,
  sync_cnt_regs_if.slave      bus,
  output logic                cnt_ovf_irq
);

  reg_sel_e wr_sel;
  reg_sel_e rd_sel;

  logic              cnt_ld;
  logic              cnt_add;
  logic              cnt_carry;
  logic [DATA_W-1:0] cnt;

  logic              run_q, run_d;
  logic              ovf_q, ovf_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] snap_val;

  assign wr_sel = decode_addr(32'(bus.reg_wr_addr));
  assign rd_sel = decode_addr(32'(bus.reg_rd_addr));

  assign cnt_ld  = bus.reg_wr_en && (wr_sel == REG_CNT);
  assign cnt_add = bus.reg_wr_en && (wr_sel == REG_TRIG);

  sync_cnt_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .run_i      (run_q),
    .ld_en_i    (cnt_ld),
    .ld_data_i  (bus.reg_wr_data),
    .add_en_i   (cnt_add),
    .add_data_i (bus.reg_wr_data),
    .cnt_o      (cnt),
    .carry_o    (cnt_carry)
  );

`ifdef SYNC_CNT_SNAPSHOT_EN
  logic [DATA_W-1:0] snap_q, snap_d;

  // Capture the pre-edge CNT on every CNT read.
  always_comb begin
    snap_d = snap_q;
    if (bus.reg_rd_en && (rd_sel == REG_CNT)) begin
      snap_d = cnt;
    end
  end

  // Snapshot register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  assign snap_val = snap_q;
`else
  assign snap_val = '0;
`endif

  // Control/status next state: RUN write, and OVF where a new carry beats a
  // same-cycle write-1-to-clear.
  always_comb begin
    run_d = run_q;
    if (bus.reg_wr_en && (wr_sel == REG_RUN)) begin
      run_d = bus.reg_wr_data[0];
    end
    ovf_d = ovf_q;
    if (bus.reg_wr_en && (wr_sel == REG_STATUS) && bus.reg_wr_data[0]) begin
      ovf_d = 1'b0;
    end
    if (cnt_carry) begin
      ovf_d = 1'b1;
    end
  end

  // Read mux over pre-edge register values; TRIG is write-only and reads 0.
  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      REG_CNT:    rd_mux = cnt;
      REG_RUN:    rd_mux = {{(DATA_W-1){1'b0}}, run_q};
      REG_STATUS: rd_mux = {{(DATA_W-1){1'b0}}, ovf_q};
      REG_SNAP:   rd_mux = snap_val;
      default:    rd_mux = '0;
    endcase
  end

  // Response pulses: ack/valid follow their strobe by one cycle; data and
  // error are zero outside a valid read.
  always_comb begin
    wr_ack_d   = bus.reg_wr_en;
    rd_valid_d = bus.reg_rd_en;
    rd_err_d   = bus.reg_rd_en && (rd_sel == REG_NONE);
    rd_data_d  = bus.reg_rd_en ? rd_mux : '0;
  end

  // Control, status and response registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      run_q      <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      run_q      <= run_d;
      ovf_q      <= ovf_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.reg_wr_ack   = wr_ack_q;
  assign bus.reg_rd_valid = rd_valid_q;
  assign bus.reg_rd_err   = rd_err_q;
  assign bus.reg_rd_data  = rd_data_q;
  assign cnt_ovf_irq      = ovf_q;

endmodule

// File: tb/tb_sync_cnt_regs.sv
// Directed bench for sync_cnt_regs: a table of bus operations with
// hand-computed results, plus short sequences for same-cycle read/write,
// overflow set-versus-clear, and reset during a pending transaction.
module tb_sync_cnt_regs;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_IDLE} op_e;

  typedef struct {
    op_e              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;      // write data, or idle cycle count
    logic [DATA_W-1:0] exp_data;  // read data expected
    logic              exp_err;
    logic              exp_irq;   // cnt_ovf_irq after the operation
  } vec_t;

  logic ACLK;
  logic ARESET;
  logic cnt_ovf_irq;

  int n_vec;
  int n_err;

  vec_t vecs[$];

  sync_cnt_regs_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sync_cnt_regs #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .bus         (bus),
    .cnt_ovf_irq (cnt_ovf_irq)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input op_e op, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data,
                             input logic [DATA_W-1:0] exp_data,
                             input logic exp_err, input logic exp_irq);
    vec_t r;
    r.op = op; r.addr = addr; r.data = data;
    r.exp_data = exp_data; r.exp_err = exp_err; r.exp_irq = exp_irq;
    return r;
  endfunction

  // Entered and left at a falling edge: drive, cross one rising edge, sample.
  task automatic apply(input vec_t x, input string tag);
    case (x.op)
      OP_WR: begin
        bus.reg_wr_en   = 1'b1;
        bus.reg_wr_addr = x.addr;
        bus.reg_wr_data = x.data;
        @(negedge ACLK);
        bus.reg_wr_en   = 1'b0;
        check({tag, "_wr_ack"}, {63'd0, bus.reg_wr_ack}, 64'd1);
      end
      OP_RD: begin
        bus.reg_rd_en   = 1'b1;
        bus.reg_rd_addr = x.addr;
        @(negedge ACLK);
        bus.reg_rd_en   = 1'b0;
        check({tag, "_rd_valid"}, {63'd0, bus.reg_rd_valid}, 64'd1);
        check({tag, "_rd_data"}, bus.reg_rd_data, x.exp_data);
        check({tag, "_rd_err"}, {63'd0, bus.reg_rd_err}, {63'd0, x.exp_err});
      end
      default: begin
        repeat (int'(x.data)) @(negedge ACLK);
      end
    endcase
    check({tag, "_irq"}, {63'd0, cnt_ovf_irq}, {63'd0, x.exp_irq});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"}, {63'd0, bus.reg_wr_ack}, 64'd0);
    check({tag, "_valid"}, {63'd0, bus.reg_rd_valid}, 64'd0);
    check({tag, "_err"}, {63'd0, bus.reg_rd_err}, 64'd0);
    check({tag, "_data"}, bus.reg_rd_data, 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.reg_wr_en   = 1'b0;
    bus.reg_wr_addr = '0;
    bus.reg_wr_data = '0;
    bus.reg_rd_en   = 1'b0;
    bus.reg_rd_addr = '0;
    ARESET = 1'b1;

    // Main table: addresses 0x00 CNT, 0x08 RUN, 0x10 TRIG, 0x18 STATUS.
    vecs.push_back(v(OP_RD,   8'h00, 0, 64'h0, 0, 0));
    vecs.push_back(v(OP_RD,   8'h08, 0, 64'h0, 0, 0));
    vecs.push_back(v(OP_RD,   8'h18, 0, 64'h0, 0, 0));
    vecs.push_back(v(OP_WR,   8'h10, 64'd1, 0, 0, 0));
    vecs.push_back(v(OP_WR,   8'h10, 64'd2, 0, 0, 0));
    vecs.push_back(v(OP_WR,   8'h10, 64'd3, 0, 0, 0));
    vecs.push_back(v(OP_RD,   8'h00, 0, 64'd6, 0, 0));
    vecs.push_back(v(OP_RD,   8'h10, 0, 64'd0, 0, 0));
    // RUN on; four idle edges then the read edge sees 6+4.
    vecs.push_back(v(OP_WR,   8'h08, 64'd1, 0, 0, 0));
    vecs.push_back(v(OP_IDLE, 8'h00, 64'd4, 0, 0, 0));
    vecs.push_back(v(OP_RD,   8'h00, 0, 64'd10, 0, 0));
    vecs.push_back(v(OP_RD,   8'h08, 0, 64'd1, 0, 0));
    vecs.push_back(v(OP_WR,   8'h08, 64'd0, 0, 0, 0));
    vecs.push_back(v(OP_RD,   8'h00, 0, 64'd13, 0, 0));
    // Wrap: FE -> FF -> 0 (carry) -> 1 over three running edges.
    vecs.push_back(v(OP_WR,   8'h00, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0));
    vecs.push_back(v(OP_WR,   8'h08, 64'd1, 0, 0, 0));
    vecs.push_back(v(OP_IDLE, 8'h00, 64'd2, 0, 0, 1));
    vecs.push_back(v(OP_WR,   8'h08, 64'd0, 0, 0, 1));
    vecs.push_back(v(OP_RD,   8'h00, 0, 64'd1, 0, 1));
    vecs.push_back(v(OP_RD,   8'h18, 0, 64'd1, 0, 1));
    vecs.push_back(v(OP_WR,   8'h18, 64'd1, 0, 0, 0));
    vecs.push_back(v(OP_RD,   8'h18, 0, 64'd0, 0, 0));
    // Running counter with same-cycle TRIG and CNT writes.
    vecs.push_back(v(OP_WR,   8'h00, 64'd5, 0, 0, 0));
    vecs.push_back(v(OP_WR,   8'h08, 64'd1, 0, 0, 0));
    vecs.push_back(v(OP_WR,   8'h10, 64'h10, 0, 0, 0));
    vecs.push_back(v(OP_RD,   8'h00, 0, 64'h16, 0, 0));
    vecs.push_back(v(OP_WR,   8'h00, 64'h40, 0, 0, 0));
    vecs.push_back(v(OP_RD,   8'h00, 0, 64'h40, 0, 0));
    vecs.push_back(v(OP_WR,   8'h08, 64'd0, 0, 0, 0));
    vecs.push_back(v(OP_RD,   8'h00, 0, 64'h42, 0, 0));
    // Unmapped and optional addresses.
    vecs.push_back(v(OP_RD,   8'h28, 0, 64'd0, 1, 0));
`ifdef SYNC_CNT_SNAPSHOT_EN
    vecs.push_back(v(OP_RD,   8'h20, 0, 64'h42, 0, 0));
`else
    vecs.push_back(v(OP_RD,   8'h20, 0, 64'd0, 1, 0));
`endif
    vecs.push_back(v(OP_WR,   8'h28, 64'h99, 0, 0, 0));
    vecs.push_back(v(OP_RD,   8'h00, 0, 64'h42, 0, 0));

    // Reset state.
    repeat (3) @(negedge ACLK);
    check_idle_outputs("reset");
    check("reset_irq", {63'd0, cnt_ovf_irq}, 64'd0);
    ARESET = 1'b0;
    @(negedge ACLK);

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Same-cycle read and write of CNT: read sees the old value.
    bus.reg_wr_en   = 1'b1;
    bus.reg_wr_addr = 8'h00;
    bus.reg_wr_data = 64'h123;
    bus.reg_rd_en   = 1'b1;
    bus.reg_rd_addr = 8'h00;
    @(negedge ACLK);
    bus.reg_wr_en = 1'b0;
    bus.reg_rd_en = 1'b0;
    check("rw_ack", {63'd0, bus.reg_wr_ack}, 64'd1);
    check("rw_valid", {63'd0, bus.reg_rd_valid}, 64'd1);
    check("rw_old_data", bus.reg_rd_data, 64'h42);
    @(negedge ACLK);
    check_idle_outputs("rw_pulse_end");
    apply(v(OP_RD, 8'h00, 0, 64'h123, 0, 0), "rw_new");

    // Carry and W1C in the same cycle: the set wins.
    apply(v(OP_WR, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0), "sc_load");
    apply(v(OP_WR, 8'h08, 64'd1, 0, 0, 0), "sc_run");
    apply(v(OP_WR, 8'h18, 64'd1, 0, 0, 1), "sc_w1c");
    apply(v(OP_WR, 8'h08, 64'd0, 0, 0, 1), "sc_stop");
    apply(v(OP_RD, 8'h18, 0, 64'd1, 0, 1), "sc_status");

    // Reset between strobe and edge: no response pulse, state cleared.
    bus.reg_rd_en   = 1'b1;
    bus.reg_rd_addr = 8'h00;
    bus.reg_wr_en   = 1'b1;
    bus.reg_wr_addr = 8'h08;
    bus.reg_wr_data = 64'd1;
    #2 ARESET = 1'b1;
    #1;
    bus.reg_rd_en = 1'b0;
    bus.reg_wr_en = 1'b0;
    @(negedge ACLK);
    check_idle_outputs("mid_rst");
    check("mid_rst_irq", {63'd0, cnt_ovf_irq}, 64'd0);
    ARESET = 1'b0;
    repeat (2) begin
      @(negedge ACLK);
      check("post_rst_valid", {63'd0, bus.reg_rd_valid}, 64'd0);
      check("post_rst_ack", {63'd0, bus.reg_wr_ack}, 64'd0);
    end
    apply(v(OP_RD, 8'h00, 0, 64'd0, 0, 0), "post_rst_cnt");
    apply(v(OP_RD, 8'h08, 0, 64'd0, 0, 0), "post_rst_run");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_cnt_regs.md
SYNC_CNT_REGS -- requirements
Module: sync_cnt_regs

Interface
REQ-001 Parameter DATA_W, default 64, register and bus data width.
REQ-002 Parameter ADDR_W, default 8, byte address width of the register bus.
REQ-003 ACLK  input  1  sole clock; all logic on rising edge.
REQ-004 ARESET  input  1  asynchronous, active-high reset.
REQ-005 reg_wr_en  input  1  one-cycle write strobe from the upstream AXI-to-sync-register bridge.
REQ-006 reg_wr_addr  input  ADDR_W  write byte address.
REQ-007 reg_wr_data  input  DATA_W  write data.
REQ-008 reg_wr_ack  output  1  write accepted, asserted the cycle after reg_wr_en.
REQ-009 reg_rd_en  input  1  one-cycle read strobe.
REQ-010 reg_rd_addr  input  ADDR_W  read byte address.
REQ-011 reg_rd_data  output  DATA_W  read data, valid with reg_rd_valid.
REQ-012 reg_rd_valid  output  1  read data valid, asserted the cycle after reg_rd_en.
REQ-013 reg_rd_err  output  1  unmapped read address, qualified by reg_rd_valid.
REQ-014 cnt_ovf_irq  output  1  level copy of the sticky overflow flag.

Function
REQ-015 Register map: 0x00 CNT (RW), 0x08 RUN (RW, bit0 only), 0x10 TRIG (WO, reads 0), 0x18 STATUS (bit0 OVF, write-1-to-clear).
REQ-016 A write to CNT shall load reg_wr_data into CNT on the next edge.
REQ-017 A write to TRIG shall add reg_wr_data to CNT on the next edge.
REQ-018 While RUN[0]=1, CNT shall increment by 1 every cycle.
REQ-019 Same cycle, RUN=1 and TRIG write: CNT shall become CNT+wr_data+1.
REQ-020 Same cycle, RUN=1 and CNT write: the write value wins, with no increment that cycle.
REQ-021 CNT arithmetic shall be modulo 2^DATA_W; any carry out of bit DATA_W-1 shall set OVF.
REQ-022 Same cycle, OVF set event and W1C clear: set wins.
REQ-023 Reads shall return the register value before that cycle's updates, registered with one-cycle latency.
REQ-024 Same cycle, read and write to the same address: the read returns the old value.
REQ-025 An unmapped read shall return 0 with reg_rd_err=1; an unmapped write shall be ignored, but reg_wr_ack is still asserted.
REQ-026 reg_wr_en and reg_rd_en may both be asserted in the same cycle; both shall complete.
REQ-027 reg_wr_ack, reg_rd_valid and reg_rd_err shall be single-cycle pulses.

Reset
REQ-028 On ARESET, CNT=0, RUN=0, OVF=0, reg_wr_ack=0, reg_rd_valid=0, reg_rd_err=0, reg_rd_data=0, cnt_ovf_irq=0.
REQ-029 An ARESET asserted mid-transaction shall abort the pending ack/valid pulse; no pulse shall be emitted after release.

Configuration
REQ-030 With macro SYNC_CNT_SNAPSHOT_EN defined, register 0x20 SNAP (RO) shall be added; any read of CNT shall latch the pre-update CNT into SNAP on the same edge, and SNAP shall reset to 0.
REQ-031 Without SYNC_CNT_SNAPSHOT_EN, address 0x20 shall be unmapped (read returns 0 with reg_rd_err=1).

Structure
REQ-032 Register offset constants (CNT, RUN, TRIG, STATUS, SNAP) and the DATA_W/ADDR_W defaults shall live in shared package sync_reg_pkg.
REQ-033 The counter datapath (load, add, increment, carry detect) shall be one sub-module, sync_cnt_core; the address decode and read pipeline shall stay in sync_cnt_regs.

Verification
REQ-034 Post-reset reads of 0x00 and 0x08 -> CNT=0, RUN=0, reg_rd_err=0, each reg_rd_valid exactly one cycle after reg_rd_en.
REQ-035 TRIG writes of 1, 2, 3 with RUN=0, then read 0x00 -> 6.
REQ-036 Write RUN=1, wait N cycles, read 0x00 -> value equals 6 plus the number of edges with RUN=1 before the read cycle.
REQ-037 CNT=0xFFFF_FFFF_FFFF_FFFE, RUN=1, wait 3 cycles -> CNT wraps to 1, OVF=1, cnt_ovf_irq=1; then write 0x18 with 1 -> OVF=0.
REQ-038 RUN=1 plus same-cycle TRIG write of 0x10 at CNT=5 -> CNT=0x16; same-cycle CNT write of 0x40 -> CNT=0x40.
REQ-039 Read 0x28 -> data 0, reg_rd_err=1; read 0x20 -> snapshot with SYNC_CNT_SNAPSHOT_EN defined, reg_rd_err=1 without it; ARESET between reg_rd_en and the following edge -> no reg_rd_valid pulse.
